// File: rtl/teclado_cajero.sv
// Customer keypad front-end for the ATM controller: debounces raw key presses and
// turns them into PIN digit, transaction-type and binary amount strobes.
module teclado_cajero #(
  parameter int DEBOUNCE    = 2,
  parameter int MAX_DIGITOS = 9
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        TARJETA_RECIBIDA,
  input  logic        TECLA_VALIDA,
  input  logic [3:0]  TECLA,
  input  logic        PIN_INCORRECTO,
  input  logic        Bloqueo,
  input  logic        BALANCE_ACTUALIZADO,
  input  logic        ENTREGAR_DINERO,
  input  logic        FONDOS_INSUFICIENTES,
  output logic [3:0]  DIGITO,
  output logic        DIGITO_STB,
  output logic        TIPO_TRANS,
  output logic        TIPO_STB,
  output logic [31:0] MONTO,
  output logic        MONTO_STB,
  output logic [2:0]  ESTADO
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PIN        = 3'd1,
    S_ESPERA_PIN = 3'd2,
    S_MONTO      = 3'd3,
    S_ESPERA_RES = 3'd4,
    S_FIN        = 3'd5,
    S_BLOQ       = 3'd6
  } state_t;

  localparam logic [3:0] DEB = 4'(DEBOUNCE);
  localparam int CNT_W = ($clog2(MAX_DIGITOS + 1) > 3) ? $clog2(MAX_DIGITOS + 1) : 3;
  localparam logic [CNT_W-1:0] MAX_D = CNT_W'(MAX_DIGITOS);

  localparam logic [3:0] K_DEPOSITO = 4'hA;
  localparam logic [3:0] K_RETIRO   = 4'hB;
  localparam logic [3:0] K_ENTER    = 4'hC;
  localparam logic [3:0] K_BORRAR   = 4'hD;

  state_t state_q, state_d;

  logic [3:0]       tecla_prev_q;
  logic [3:0]       deb_cnt_q, deb_cnt_d;
  logic             lock_q, lock_d;
  logic             key_ev;
  logic             is_digit;

  logic [CNT_W-1:0] ndig_q, ndig_d;
  logic [31:0]      acc_q, acc_d;

  logic [3:0]       digito_q, digito_d;
  logic             digito_stb_q, digito_stb_d;
  logic             tipo_q, tipo_d;
  logic             tipo_stb_q, tipo_stb_d;
  logic [31:0]      monto_q, monto_d;
  logic             monto_stb_q, monto_stb_d;

  // Debounce: the count restarts at 1 whenever the code changes while held; the lock
  // keeps a long press (or a code change mid-press) from producing a second event.
  always_comb begin
    deb_cnt_d = 4'd0;
    lock_d    = 1'b0;
    key_ev    = 1'b0;
    if (TECLA_VALIDA) begin
      if (TECLA != tecla_prev_q) begin
        deb_cnt_d = 4'd1;
      end else if (deb_cnt_q < DEB) begin
        deb_cnt_d = deb_cnt_q + 4'd1;
      end else begin
        deb_cnt_d = deb_cnt_q;
      end
      key_ev = !lock_q && (deb_cnt_d == DEB);
      lock_d = lock_q || key_ev;
    end
  end

  assign is_digit = (TECLA <= 4'd9);

  always_comb begin
    state_d      = state_q;
    ndig_d       = ndig_q;
    acc_d        = acc_q;
    digito_d     = digito_q;
    digito_stb_d = 1'b0;
    tipo_d       = tipo_q;
    tipo_stb_d   = 1'b0;
    monto_d      = monto_q;
    monto_stb_d  = 1'b0;

    if (Bloqueo && state_q != S_IDLE) begin
      state_d = S_BLOQ;
    end else if (!TARJETA_RECIBIDA && state_q != S_BLOQ) begin
      // Card gone: abandon the session, keep the last amount visible.
      state_d = S_IDLE;
      ndig_d  = '0;
      acc_d   = 32'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_PIN;
          ndig_d  = '0;
        end
        S_PIN: begin
          if (key_ev && is_digit) begin
            digito_d     = TECLA;
            digito_stb_d = 1'b1;
            if (ndig_q == CNT_W'(3)) begin
              state_d = S_ESPERA_PIN;
              ndig_d  = '0;
            end else begin
              ndig_d = ndig_q + CNT_W'(1);
            end
          end
        end
        S_ESPERA_PIN: begin
          if (PIN_INCORRECTO) begin
            state_d = S_PIN;
            ndig_d  = '0;
          end else if (key_ev && (TECLA == K_DEPOSITO || TECLA == K_RETIRO)) begin
            tipo_d     = (TECLA == K_RETIRO);
            tipo_stb_d = 1'b1;
            state_d    = S_MONTO;
            acc_d      = 32'd0;
            ndig_d     = '0;
          end
        end
        S_MONTO: begin
          if (key_ev) begin
            if (is_digit) begin
              if (ndig_q < MAX_D) begin
                acc_d  = (acc_q << 3) + (acc_q << 1) + 32'(TECLA);
                ndig_d = ndig_q + CNT_W'(1);
              end
            end else if (TECLA == K_BORRAR) begin
              acc_d  = 32'd0;
              ndig_d = '0;
            end else if (TECLA == K_ENTER && ndig_q != '0) begin
              monto_d     = acc_q;
              monto_stb_d = 1'b1;
              state_d     = S_ESPERA_RES;
            end
          end
        end
        S_ESPERA_RES: begin
          if (BALANCE_ACTUALIZADO || ENTREGAR_DINERO || FONDOS_INSUFICIENTES) begin
            state_d = S_FIN;
          end
        end
        S_FIN:   state_d = S_FIN;
        S_BLOQ:  state_d = S_BLOQ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      tecla_prev_q <= 4'd0;
      deb_cnt_q    <= 4'd0;
      lock_q       <= 1'b0;
      ndig_q       <= '0;
      acc_q        <= 32'd0;
      digito_q     <= 4'd0;
      digito_stb_q <= 1'b0;
      tipo_q       <= 1'b0;
      tipo_stb_q   <= 1'b0;
      monto_q      <= 32'd0;
      monto_stb_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tecla_prev_q <= TECLA;
      deb_cnt_q    <= deb_cnt_d;
      lock_q       <= lock_d;
      ndig_q       <= ndig_d;
      acc_q        <= acc_d;
      digito_q     <= digito_d;
      digito_stb_q <= digito_stb_d;
      tipo_q       <= tipo_d;
      tipo_stb_q   <= tipo_stb_d;
      monto_q      <= monto_d;
      monto_stb_q  <= monto_stb_d;
    end
  end

  assign DIGITO     = digito_q;
  assign DIGITO_STB = digito_stb_q;
  assign TIPO_TRANS = tipo_q;
  assign TIPO_STB   = tipo_stb_q;
  assign MONTO      = monto_q;
  assign MONTO_STB  = monto_stb_q;
  assign ESTADO     = state_q;

endmodule
